// File: rtl/reg_file.sv
// General-purpose register file: two combinational read ports, one write port.
// Register 0 optionally hardwired to zero.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  enable,
    input  logic                  rw,
    output logic [DATA_WIDTH-1:0] out1,
    output logic [DATA_WIDTH-1:0] out2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic rd_is_zero;
    logic rs1_is_zero;
    logic rs2_is_zero;
    logic wr_en;

    assign rd_is_zero  = (ZERO_REG != 0) && (rd == '0);
    assign rs1_is_zero = (ZERO_REG != 0) && (rs1 == '0);
    assign rs2_is_zero = (ZERO_REG != 0) && (rs2 == '0);

    assign wr_en = enable && rw && !rd_is_zero;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd] <= din;
        end
    end

    // No bypass of din: a same-cycle write only becomes visible after the edge.
    always_comb begin
        out1 = '0;
        out2 = '0;
        if (enable) begin
            if (!rs1_is_zero) begin
                out1 = regs[rs1];
            end
            if (!rs2_is_zero) begin
                out2 = regs[rs2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Each scenario task drives vectors and checks against hand-derived values.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] din;
    logic        enable;
    logic        rw;
    logic [31:0] out1;
    logic [31:0] out2;

    int checks;
    int errors;

    logic [31:0] model [32];

    reg_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rs1(rs1),
        .rs2(rs2),
        .rd(rd),
        .din(din),
        .enable(enable),
        .rw(rw),
        .out1(out1),
        .out2(out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        rw     = 1'b0;
        rd     = 5'd0;
        din    = 32'h0;
        tick();
        reset = 1'b1;
        rs1   = 5'd5;
        rs2   = 5'd31;
        #1;
        checks++;
        if (out1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_out1: got %h want %h", out1, 32'h0);
        end
        checks++;
        if (out2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_out2: got %h want %h", out2, 32'h0);
        end
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic test_write_read();
        enable = 1'b1;
        rw     = 1'b1;
        rd     = 5'd17;
        din    = 32'd37;
        tick();
        model[17] = 32'd37;
        rw  = 1'b0;
        rs1 = 5'd17;
        rs2 = 5'd5;
        #1;
        checks++;
        if (out1 !== 32'd37) begin
            errors++;
            $display("FAIL wr_r17: got %h want %h", out1, 32'd37);
        end
        checks++;
        if (out2 !== 32'h0) begin
            errors++;
            $display("FAIL rd_r5: got %h want %h", out2, 32'h0);
        end
    endtask

    task automatic test_pairs();
        logic [31:0] v;
        enable = 1'b1;
        for (int k = 0; k < 32; k += 2) begin
            for (int j = 0; j < 2; j++) begin
                v   = $urandom;
                rw  = 1'b1;
                rd  = 5'(k + j);
                din = v;
                tick();
                if (k + j != 0) model[k + j] = v;
            end
        end
        rw = 1'b0;
        for (int k = 0; k < 32; k += 2) begin
            rs1 = 5'(k);
            rs2 = 5'(k + 1);
            #1;
            checks++;
            if (out1 !== model[k]) begin
                errors++;
                $display("FAIL pair_out1 r%0d: got %h want %h",
                         k, out1, model[k]);
            end
            checks++;
            if (out2 !== model[k + 1]) begin
                errors++;
                $display("FAIL pair_out2 r%0d: got %h want %h",
                         k + 1, out2, model[k + 1]);
            end
        end
        rs1 = 5'd0;
        rs2 = 5'd0;
        #1;
        checks++;
        if (out1 !== 32'h0 || out2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg: got %h/%h want 0/0", out1, out2);
        end
        rs1 = 5'd22;
        rs2 = 5'd22;
        #1;
        checks++;
        if (out1 !== model[22] || out2 !== model[22]) begin
            errors++;
            $display("FAIL same_addr: got %h/%h want %h",
                     out1, out2, model[22]);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        rw     = 1'b1;
        rd     = 5'd3;
        din    = 32'hDEADBEEF;
        rs1    = 5'd3;
        rs2    = 5'd17;
        #1;
        checks++;
        if (out1 !== 32'h0 || out2 !== 32'h0) begin
            errors++;
            $display("FAIL disabled_out: got %h/%h want 0/0", out1, out2);
        end
        tick();
        enable = 1'b1;
        rw     = 1'b0;
        #1;
        checks++;
        if (out1 !== model[3]) begin
            errors++;
            $display("FAIL disabled_write: got %h want %h", out1, model[3]);
        end
        checks++;
        if (out2 !== model[17]) begin
            errors++;
            $display("FAIL retain: got %h want %h", out2, model[17]);
        end
        rs1 = 5'd10;
        rw  = 1'b0;
        rd  = 5'd10;
        din = 32'h0BAD0BAD;
        tick();
        checks++;
        if (out1 !== model[10]) begin
            errors++;
            $display("FAIL rw0_write: got %h want %h", out1, model[10]);
        end
    endtask

    task automatic test_back_to_back();
        enable = 1'b1;
        rw     = 1'b1;
        rd     = 5'd9;
        din    = 32'h11;
        tick();
        rs1 = 5'd9;
        din = 32'h22;
        #1;
        checks++;
        if (out1 !== 32'h11) begin
            errors++;
            $display("FAIL rdw_before: got %h want %h", out1, 32'h11);
        end
        tick();
        rw = 1'b0;
        checks++;
        if (out1 !== 32'h22) begin
            errors++;
            $display("FAIL rdw_after: got %h want %h", out1, 32'h22);
        end
        model[9] = 32'h22;
    endtask

    task automatic test_reset_priority();
        int bad;
        enable = 1'b1;
        reset  = 1'b0;
        rw     = 1'b1;
        rd     = 5'd4;
        din    = 32'h55;
        tick();
        reset = 1'b1;
        rw    = 1'b0;
        rs1   = 5'd4;
        rs2   = 5'd9;
        #1;
        checks++;
        if (out1 !== 32'h0) begin
            errors++;
            $display("FAIL rst_prio_r4: got %h want %h", out1, 32'h0);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            if (out1 !== 32'h0 || out2 !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_clear_all: got %0d nonzero reads want 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        enable = 1'b0;
        rw     = 1'b0;
        rs1    = 5'd0;
        rs2    = 5'd0;
        rd     = 5'd0;
        din    = 32'h0;
        #2;
        test_reset();
        test_write_read();
        test_pairs();
        test_enable();
        test_back_to_back();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
